omem_drain: RTL and testbench

Downstream readback stage for the MAC array's output memory (OMEM).
- After a tile completes, a START pulse makes the block read OMEM rows 0..LAST_ROW, one 64-bit word per row.
- Each word is split into four signed 16-bit elements and sent lane 0 first on a valid/ready stream to the host/DMA side.
- While BUSY, the block owns the OMEM port; the top-level mux hands it the port only while BUSY=1.

---
 rtl/omem_drain.sv | 129 ++++++++++++
 tb/tb_omem_drain.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/omem_drain.sv
// OMEM readback stage: streams rows 0..LAST_ROW as four 16-bit lanes.
// Optional macro OMEM_DRAIN_RELU_EN clamps negative elements to zero.
module omem_drain #(
  parameter int DW = 64,
  parameter int EW = 16,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [AW-1:0] LAST_ROW,
  input  logic          ABORT,
  output logic          EN_O,
  output logic          RW_O,
  output logic [AW-1:0] ADDR_O,
  input  logic [DW-1:0] RDATA_O,
  output logic          M_VALID,
  input  logic          M_READY,
  output logic [EW-1:0] M_DATA,
  output logic          M_LAST,
  output logic          BUSY,
  output logic          DONE
);

  localparam int NL = DW / EW;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WT,
    SEND
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   row_q, row_d;
  logic [AW-1:0]   last_q, last_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic            done_q, done_d;

  logic            lane_end;
  logic            row_end;
  logic [EW-1:0]   elem;
  logic [EW-1:0]   elem_c;

  assign lane_end = (lane_q == LW'(NL - 1));
  assign row_end  = (row_q == last_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      row_q   <= '0;
      last_q  <= '0;
      lane_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      last_q  <= last_d;
      lane_q  <= lane_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    last_d  = last_q;
    lane_d  = lane_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START && !ABORT) begin
          row_d   = '0;
          last_d  = LAST_ROW;
          lane_d  = '0;
          state_d = RD;
        end
      end
      RD: state_d = WT;
      WT: begin
        hold_d  = RDATA_O;
        state_d = SEND;
      end
      SEND: begin
        if (M_READY) begin
          if (!lane_end) begin
            lane_d = lane_q + 1'b1;
          end else if (!row_end) begin
            row_d   = row_q + 1'b1;
            lane_d  = '0;
            state_d = RD;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort beats everything, including a completing final handshake.
    if (ABORT && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  assign elem = hold_q[lane_q*EW +: EW];

`ifdef OMEM_DRAIN_RELU_EN
  assign elem_c = elem[EW-1] ? '0 : elem;
`else
  assign elem_c = elem;
`endif

  assign EN_O    = (state_q == RD);
  assign RW_O    = 1'b0;
  assign ADDR_O  = (state_q == RD) ? row_q : '0;
  assign M_VALID = (state_q == SEND);
  assign M_DATA  = M_VALID ? elem_c : '0;
  assign M_LAST  = M_VALID && lane_end && row_end;
  assign BUSY    = (state_q != IDLE);
  assign DONE    = done_q;

endmodule

// File: tb/tb_omem_drain.sv
// Randomized self-checking bench for omem_drain.
// Expected streams come from a queue model built from the OMEM contents.
module tb_omem_drain;
  localparam int DW = 64;
  localparam int EW = 16;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [AW-1:0] LAST_ROW;
  logic          ABORT;
  logic          EN_O;
  logic          RW_O;
  logic [AW-1:0] ADDR_O;
  logic [DW-1:0] RDATA_O;
  logic          M_VALID;
  logic          M_READY;
  logic [EW-1:0] M_DATA;
  logic          M_LAST;
  logic          BUSY;
  logic          DONE;

  logic [DW-1:0] mem [16];

  int n_chk = 0;
  int n_err = 0;

  omem_drain #(.DW(DW), .EW(EW), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .LAST_ROW(LAST_ROW),
    .ABORT(ABORT), .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O),
    .RDATA_O(RDATA_O), .M_VALID(M_VALID), .M_READY(M_READY),
    .M_DATA(M_DATA), .M_LAST(M_LAST), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // OMEM model: read data valid the cycle after the enable
  always @(posedge CLK) begin
    if (EN_O) RDATA_O <= mem[ADDR_O];
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_elem(input logic [63:0] w,
                                             input int lane);
    logic [15:0] e;
    e = w[lane*16 +: 16];
`ifdef OMEM_DRAIN_RELU_EN
    if (e[15]) e = 16'h0000;
`endif
    return e;
  endfunction

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      chk("idle_busy", BUSY, 0);
      chk("idle_en", EN_O, 0);
      chk("idle_done", DONE, 0);
      chk("idle_valid", M_VALID, 0);
    end
  endtask

  // rmode 0: always ready, 1: random ready. abort_idx: element index
  // at which ABORT is raised (-1 none). hold: cycles START stays high.
  // pre: START already raised by the previous call. chain: raise START
  // in the DONE cycle with LAST_ROW=nlast.
  task automatic run_drain(input int last, input int rmode,
                           input int abort_idx, input int hold,
                           input bit pre, input bit chain,
                           input int nlast);
    logic [16:0] exp_q[$];
    int          addr_q[$];
    logic [16:0] e;
    int          total;
    int          hs;
    int          prev_hs_t;
    int          first_v;
    bit          stall;
    logic [15:0] pd;
    logic        pl;
    bit          rdy;
    bit          ab;
    total = (last + 1) * 4;
    hs = 0;
    prev_hs_t = -1;
    first_v = -1;
    stall = 0;
    pd = '0;
    pl = 1'b0;
    for (int r = 0; r <= last; r++) begin
      addr_q.push_back(r);
      for (int l = 0; l < 4; l++)
        exp_q.push_back({(r == last && l == 3), model_elem(mem[r], l)});
    end
    if (!pre) begin
      START = 1'b1;
      LAST_ROW = AW'(last);
    end
    M_READY = 1'b0;
    ABORT = 1'b0;
    for (int t = 1; t <= 3000; t++) begin
      @(posedge CLK); #1;
      START = (t < hold);
      if (t == 1) begin
        chk("en_after_start", EN_O, 1);
        chk("busy_after_start", BUSY, 1);
        chk("rw_read", RW_O, 0);
      end
      if (EN_O) begin
        if (addr_q.size() == 0) chk("extra_en", EN_O, 0);
        else chk("addr", ADDR_O, addr_q.pop_front());
      end
      if (M_VALID && first_v < 0) begin
        first_v = t;
        chk("latency", t, 3);
      end
      if (stall) begin
        chk("stall_valid", M_VALID, 1);
        chk("stall_data", M_DATA, pd);
        chk("stall_last", M_LAST, pl);
      end
      if (!M_VALID) begin
        chk("novalid_data", M_DATA, 0);
        chk("novalid_last", M_LAST, 0);
      end
      if (DONE) begin
        chk("done_time", t, prev_hs_t + 1);
        chk("done_count", hs, total);
        chk("addr_left", addr_q.size(), 0);
        if (chain) begin
          START = 1'b1;
          LAST_ROW = AW'(nlast);
        end
        M_READY = 1'b0;
        return;
      end
      ab = (abort_idx >= 0) && M_VALID && (hs == abort_idx);
      rdy = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      M_READY = rdy;
      ABORT = ab;
      stall = M_VALID && !rdy;
      pd = M_DATA;
      pl = M_LAST;
      if (M_VALID && rdy) begin
        if (exp_q.size() == 0) begin
          chk("extra_hs", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data", M_DATA, e[15:0]);
          chk("last", M_LAST, e[16]);
        end
        if (rmode == 0 && hs > 0)
          chk("gap", t - prev_hs_t, (hs % 4 == 0) ? 3 : 1);
        prev_hs_t = t;
        hs++;
      end
      if (ab) begin
        @(posedge CLK); #1;
        ABORT = 1'b0;
        M_READY = 1'b0;
        chk("abort_count", hs, abort_idx + 1);
        for (int k = 0; k < 8; k++) begin
          chk("abort_busy", BUSY, 0);
          chk("abort_valid", M_VALID, 0);
          chk("abort_en", EN_O, 0);
          chk("abort_done", DONE, 0);
          @(posedge CLK); #1;
        end
        return;
      end
    end
    chk("timeout", 0, 1);
    START = 1'b0;
    M_READY = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    M_READY = 1'b0;
    LAST_ROW = '0;
    RDATA_O = '0;
    for (int r = 0; r < 16; r++) mem[r] = {$urandom, $urandom};

    // reset values
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_valid", M_VALID, 0);
    chk("rst_en", EN_O, 0);
    chk("rst_addr", ADDR_O, 0);
    chk("rst_done", DONE, 0);
    chk("rst_data", M_DATA, 0);
    chk("rst_last", M_LAST, 0);
    RST = 1'b0;

    // reset mid-SEND
    @(posedge CLK); #1;
    START = 1'b1;
    LAST_ROW = 4'd2;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      if (M_VALID) break;
    end
    chk("reach_send", M_VALID, 1);
    #2 RST = 1'b1;
    #1;
    chk("midrst_busy", BUSY, 0);
    chk("midrst_valid", M_VALID, 0);
    chk("midrst_data", M_DATA, 0);
    chk("midrst_last", M_LAST, 0);
    chk("midrst_en", EN_O, 0);
    chk("midrst_done", DONE, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    idle_check(10);

    // single row, known pattern
    mem[0] = 64'h0004_FFFD_0002_0001;
    run_drain(0, 0, -1, 1, 0, 0, 0);

    // full drain, lane = row + lane index
    for (int r = 0; r < 16; r++)
      mem[r] = {16'(r + 3), 16'(r + 2), 16'(r + 1), 16'(r)};
    run_drain(15, 0, -1, 1, 0, 0, 0);
    idle_check(2);

    // backpressure with same pattern, then random data and lengths
    run_drain(15, 1, -1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 16; r++) mem[r] = {$urandom, $urandom};
      run_drain(int'($urandom_range(0, 15)), 1, -1, 1, 0, 0, 0);
    end

    // abort at row 3 lane 1, then a clean restart
    run_drain(5, 0, 13, 1, 0, 0, 0);
    run_drain(1, 0, -1, 1, 0, 0, 0);

    // START held for 10 cycles during a drain
    run_drain(2, 0, -1, 10, 0, 0, 0);
    idle_check(5);

    // START in the DONE cycle chains a second drain
    run_drain(2, 0, -1, 1, 0, 1, 1);
    run_drain(1, 1, -1, 1, 1, 0, 0);
    idle_check(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
